// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, opcodes, decode enums,
// the ID/EX control bundle and the immediate generator.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_R = 3'd5
    } imm_fmt_e;

    // mem_size carries funct3 for loads, stores and branch conditions
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       branch;
        logic       jump;
        logic       jalr;
        wb_sel_e    wb_sel;
        logic       ecall;
        logic       ebreak;
    } ctrl_t;

    // Sign-extended immediate from instruction bits [31:7]
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] i, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm_gen = {i[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm_gen = '0;
        endcase
    endfunction

    // Base ALU operation selected by funct3 (shift/sub variants resolved by caller)
    function automatic alu_op_e alu_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_f3 = ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x XLEN integer register file: two combinational read ports with
// same-cycle writeback bypass, one write port, x0 hardwired to zero.
module regfile
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [32];

    // Array update: synchronous clear, writes to x0 dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 is zero, pending writeback is forwarded
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == 5'd0)             rdata1 = '0;
        else if (we && waddr == raddr1) rdata1 = wdata;
        if (raddr2 == 5'd0)             rdata2 = '0;
        else if (we && waddr == raddr2) rdata2 = wdata;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, register file read, load-use
// hazard detection and the ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] ResetPc = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] instrD_i,
    input  logic [XLEN-1:0] pcD_i,
    input  logic            tb_updateD_i,
    input  logic            flushE_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stallFD_o,
    output logic [XLEN-1:0] pcE_o,
    output logic [XLEN-1:0] instrE_o,
    output logic [XLEN-1:0] rs1_dataE_o,
    output logic [XLEN-1:0] rs2_dataE_o,
    output logic [XLEN-1:0] immE_o,
    output logic [4:0]      rs1E_o,
    output logic [4:0]      rs2E_o,
    output logic [4:0]      rdE_o,
    output ctrl_t           ctrlE_o,
    output logic            tb_updateE_o,
    output logic            illegalE_o
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    ctrl_t           ctrl_p0;
    imm_fmt_e        fmt_p0;
    logic            illegal_p0;
    logic            use_rs1_p0, use_rs2_p0;
    logic [XLEN-1:0] rs1_data_p0, rs2_data_p0;

    assign opcode = instrD_i[6:0];
    assign f3     = instrD_i[14:12];
    assign f7     = instrD_i[31:25];
    assign rs1_p0 = instrD_i[19:15];
    assign rs2_p0 = instrD_i[24:20];
    assign rd_p0  = instrD_i[11:7];

    regfile u_regfile (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raddr1 (rs1_p0),
        .rdata1 (rs1_data_p0),
        .raddr2 (rs2_p0),
        .rdata2 (rs2_data_p0),
        .we     (wb_en_i),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i)
    );

    // Instruction decode into control bundle, immediate format and illegal flag
    always_comb begin
        ctrl_p0    = '0;
        fmt_p0     = IMM_I;
        illegal_p0 = 1'b0;
        case (opcode)
            OP_LUI: begin
                fmt_p0 = IMM_U;
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_op      = ALU_PASSB;
            end
            OP_AUIPC: begin
                fmt_p0 = IMM_U;
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_src_pc  = 1'b1;
            end
            OP_JAL: begin
                fmt_p0 = IMM_J;
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.jump        = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_src_pc  = 1'b1;
                ctrl_p0.wb_sel      = WB_PC4;
            end
            OP_JALR: begin
                illegal_p0 = (f3 != 3'd0);
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.jump        = 1'b1;
                ctrl_p0.jalr        = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.wb_sel      = WB_PC4;
            end
            OP_BRANCH: begin
                fmt_p0 = IMM_B;
                illegal_p0 = (f3 == 3'd2) || (f3 == 3'd3);
                ctrl_p0.branch   = 1'b1;
                ctrl_p0.mem_size = f3;
                ctrl_p0.alu_op   = ALU_SUB;
            end
            OP_LOAD: begin
                illegal_p0 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.mem_read    = 1'b1;
                ctrl_p0.mem_size    = f3;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.wb_sel      = WB_MEM;
            end
            OP_STORE: begin
                fmt_p0 = IMM_S;
                illegal_p0 = (f3 > 3'd2);
                ctrl_p0.mem_write   = 1'b1;
                ctrl_p0.mem_size    = f3;
                ctrl_p0.alu_src_imm = 1'b1;
            end
            OP_IMM: begin
                ctrl_p0.reg_write   = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_op      = alu_f3(f3);
                if (f3 == 3'd1) begin
                    illegal_p0 = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      ctrl_p0.alu_op = ALU_SRA;
                    else if (f7 != 7'h00) illegal_p0 = 1'b1;
                end
            end
            OP_OP: begin
                fmt_p0 = IMM_R;
                ctrl_p0.reg_write = 1'b1;
                ctrl_p0.alu_op    = alu_f3(f3);
                if (f7 == 7'h20 && f3 == 3'd0)      ctrl_p0.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) ctrl_p0.alu_op = ALU_SRA;
                else if (f7 != 7'h00)               illegal_p0 = 1'b1;
            end
            OP_FENCE: begin
                illegal_p0 = (f3 != 3'd0);
            end
            OP_SYSTEM: begin
                if (instrD_i == 32'h0000_0073)      ctrl_p0.ecall  = 1'b1;
                else if (instrD_i == 32'h0010_0073) ctrl_p0.ebreak = 1'b1;
                else                                illegal_p0 = 1'b1;
            end
            default: illegal_p0 = 1'b1;
        endcase
        if (illegal_p0) ctrl_p0 = '0;
    end

    assign use_rs1_p0 = (fmt_p0 != IMM_U) && (fmt_p0 != IMM_J);
    assign use_rs2_p0 = (fmt_p0 == IMM_R) || (fmt_p0 == IMM_S) || (fmt_p0 == IMM_B);

    // Load-use hazard against the load currently in EX; a flush overrides it
    assign stallFD_o = ctrlE_o.mem_read && (rdE_o != 5'd0) &&
                       ((use_rs1_p0 && rs1_p0 == rdE_o) || (use_rs2_p0 && rs2_p0 == rdE_o)) &&
                       !flushE_i;

    // ID/EX register: bubble on reset, flush or stall, otherwise decoded fields
    always_ff @(posedge clk_i) begin
        if (rst_i || flushE_i || stallFD_o) begin
            pcE_o        <= ResetPc;
            instrE_o     <= NOP_INSTR;
            rs1_dataE_o  <= '0;
            rs2_dataE_o  <= '0;
            immE_o       <= '0;
            rs1E_o       <= '0;
            rs2E_o       <= '0;
            rdE_o        <= '0;
            ctrlE_o      <= '0;
            tb_updateE_o <= 1'b0;
            illegalE_o   <= 1'b0;
        end else begin
            pcE_o        <= pcD_i;
            instrE_o     <= instrD_i;
            rs1_dataE_o  <= rs1_data_p0;
            rs2_dataE_o  <= rs2_data_p0;
            immE_o       <= imm_gen(instrD_i[31:7], fmt_p0);
            rs1E_o       <= use_rs1_p0 ? rs1_p0 : 5'd0;
            rs2E_o       <= use_rs2_p0 ? rs2_p0 : 5'd0;
            rdE_o        <= ctrl_p0.reg_write ? rd_p0 : 5'd0;
            ctrlE_o      <= ctrl_p0;
            tb_updateE_o <= tb_updateD_i;
            illegalE_o   <= illegal_p0;
        end
    end

endmodule
